r_exec_unit: RTL

- Parametrised R-type execution unit, successor to the single-cycle R-type datapath.
- Executes all RV32I R-type ops. Optionally executes the RV32M ops MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, using an iterative multi-cycle engine.
- Sits between decode and writeback. Uses a valid/ready handshake on both sides. Supports kill for pipeline flush.

---
 rtl/rv_r_pkg.sv | 47 ++++
 rtl/r_muldiv_iter.sv | 101 ++++++++++
 rtl/r_exec_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rv_r_pkg.sv
// Shared types and constants for the R-type execution unit and its
// iterative multiply/divide engine.
package rv_r_pkg;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Encoding is the decode key {funct7[5], funct7[0], funct3}
  typedef enum logic [4:0] {
    ADD    = 5'b00000,
    SLL    = 5'b00001,
    SLT    = 5'b00010,
    SLTU   = 5'b00011,
    XOR    = 5'b00100,
    SRL    = 5'b00101,
    OR     = 5'b00110,
    AND    = 5'b00111,
    MUL    = 5'b01000,
    MULH   = 5'b01001,
    MULHSU = 5'b01010,
    MULHU  = 5'b01011,
    DIV    = 5'b01100,
    DIVU   = 5'b01101,
    REM    = 5'b01110,
    REMU   = 5'b01111,
    SUB    = 5'b10000,
    SRA    = 5'b10101
  } r_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } r_state_e;

  function automatic logic is_mul_op(input r_op_e op);
    return op inside {MUL, MULH, MULHSU, MULHU};
  endfunction

  function automatic logic is_div_op(input r_op_e op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

endpackage

// File: rtl/r_muldiv_iter.sv
// Shared iterative engine: shift-add multiplier and restoring divider on
// operand magnitudes, with iteration counter and final sign correction.
module r_muldiv_iter
  import rv_r_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            step_i,
  input  r_op_e           op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            last_o,
  output logic [XLEN-1:0] res_o
);
  localparam int CW = $clog2(XLEN);

  logic [2*XLEN-1:0] acc_q, acc_d, acc_src_s, prod_s;
  logic [XLEN-1:0]   opd_q, opd_src_s, a_mag_s, b_mag_s, quo_s, rem_s;
  logic [XLEN:0]     rem_sh_s, diff_s, sum_s;
  logic [CW-1:0]     cnt_q;
  logic              is_div_q, is_div_src_s, neg_q, neg_init_s, a_neg_s, b_neg_s;
  r_op_e             op_q;

  // Operand magnitudes and the iteration source (fresh operands on start)
  always_comb begin
    a_neg_s    = (op_i inside {MULH, MULHSU, DIV, REM}) & a_i[XLEN-1];
    b_neg_s    = (op_i inside {MULH, DIV, REM}) & b_i[XLEN-1];
    a_mag_s    = a_neg_s ? -a_i : a_i;
    b_mag_s    = b_neg_s ? -b_i : b_i;
    neg_init_s = (op_i == REM) ? a_neg_s : (a_neg_s ^ b_neg_s);
    if (start_i) begin
      is_div_src_s = is_div_op(op_i);
      acc_src_s    = {{XLEN{1'b0}}, (is_div_src_s ? a_mag_s : b_mag_s)};
      opd_src_s    = is_div_src_s ? b_mag_s : a_mag_s;
    end else begin
      is_div_src_s = is_div_q;
      acc_src_s    = acc_q;
      opd_src_s    = opd_q;
    end
  end

  // One multiply or divide iteration; the first runs on the accept edge so
  // the whole op fits in XLEN+1 cycles including the fix-up
  always_comb begin
    rem_sh_s = {acc_src_s[2*XLEN-1:XLEN], acc_src_s[XLEN-1]};
    diff_s   = rem_sh_s - {1'b0, opd_src_s};
    sum_s    = {1'b0, acc_src_s[2*XLEN-1:XLEN]}
             + (acc_src_s[0] ? {1'b0, opd_src_s} : {(XLEN+1){1'b0}});
    if (is_div_src_s) begin
      if (rem_sh_s >= {1'b0, opd_src_s}) begin
        acc_d = {diff_s[XLEN-1:0], acc_src_s[XLEN-2:0], 1'b1};
      end else begin
        acc_d = {rem_sh_s[XLEN-1:0], acc_src_s[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_d = {sum_s, acc_src_s[XLEN-1:1]};
    end
  end

  // Sign correction and word selection for the fix-up cycle
  always_comb begin
    prod_s = neg_q ? -acc_q : acc_q;
    quo_s  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      MUL:                 res_o = prod_s[XLEN-1:0];
      MULH, MULHSU, MULHU: res_o = prod_s[2*XLEN-1:XLEN];
      DIV, DIVU:           res_o = quo_s;
      REM, REMU:           res_o = rem_s;
      default:             res_o = {XLEN{1'b0}};
    endcase
  end

  // Engine state and iteration counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      opd_q    <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      op_q     <= ADD;
    end else if (start_i) begin
      acc_q    <= acc_d;
      opd_q    <= opd_src_s;
      cnt_q    <= '0;
      is_div_q <= is_div_src_s;
      neg_q    <= neg_init_s;
      op_q     <= op_i;
    end else if (step_i) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign last_o = (cnt_q == CW'(XLEN-2));

endmodule

// File: rtl/r_exec_unit.sv
// R-type execution unit: decode, single-cycle ALU, divide special cases,
// valid/ready handshake and control FSM around the iterative M engine.
module r_exec_unit
  import rv_r_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [TAG_W-1:0] rd_tag_in,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] rd_tag_out,
  output logic             illegal
);
  localparam int              SHW      = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  r_state_e         state_q;
  logic             out_valid_q, illegal_q, rdy_en_q;
  logic [XLEN-1:0]  result_q, alu_s, quick_res_s, md_res_s;
  logic [TAG_W-1:0] tag_q;
  r_op_e            op_s;
  logic [SHW-1:0]   shamt_s;
  logic             legal_s, is_mul_s, is_div_s, div0_s, ovf_s, quick_s;
  logic             accept_s, md_start_s, md_step_s, md_last_s;

  // Decode and classification of the presented request
  always_comb begin
    op_s     = r_op_e'({funct7[5], funct7[0], funct3});
    legal_s  = (funct7 == F7_BASE)
             | ((funct7 == F7_ALT) & ((funct3 == 3'b000) | (funct3 == 3'b101)))
             | ((funct7 == F7_MULDIV) & ENABLE_M);
    is_mul_s = legal_s & is_mul_op(op_s);
    is_div_s = legal_s & is_div_op(op_s);
    div0_s   = (rs2_val == {XLEN{1'b0}});
    ovf_s    = ((op_s == DIV) | (op_s == REM)) & (rs1_val == MOST_NEG)
             & (rs2_val == {XLEN{1'b1}});
    quick_s  = ~(is_mul_s | (is_div_s & ~div0_s & ~ovf_s));
  end

  // Single-cycle ALU, including divide-by-zero and overflow results
  always_comb begin
    shamt_s = rs2_val[SHW-1:0];
    case (op_s)
      ADD:       alu_s = rs1_val + rs2_val;
      SUB:       alu_s = rs1_val - rs2_val;
      SLL:       alu_s = rs1_val << shamt_s;
      SLT:       alu_s = {{(XLEN-1){1'b0}}, ($signed(rs1_val) < $signed(rs2_val))};
      SLTU:      alu_s = {{(XLEN-1){1'b0}}, (rs1_val < rs2_val)};
      XOR:       alu_s = rs1_val ^ rs2_val;
      SRL:       alu_s = rs1_val >> shamt_s;
      SRA:       alu_s = $signed(rs1_val) >>> shamt_s;
      OR:        alu_s = rs1_val | rs2_val;
      AND:       alu_s = rs1_val & rs2_val;
      DIV, DIVU: alu_s = div0_s ? {XLEN{1'b1}} : MOST_NEG;
      REM, REMU: alu_s = div0_s ? rs1_val : {XLEN{1'b0}};
      default:   alu_s = {XLEN{1'b0}};
    endcase
    quick_res_s = legal_s ? alu_s : {XLEN{1'b0}};
  end

  assign in_ready   = rdy_en_q & ~kill
                    & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
  assign accept_s   = in_valid & in_ready;
  assign md_start_s = accept_s & ~quick_s;
  assign md_step_s  = ((state_q == ST_MUL) | (state_q == ST_DIV)) & ~kill;

  r_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .start_i (md_start_s),
    .step_i  (md_step_s),
    .op_i    (op_s),
    .a_i     (rs1_val),
    .b_i     (rs2_val),
    .last_o  (md_last_s),
    .res_o   (md_res_s)
  );

  // Control FSM with registered result-side outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      tag_q       <= '0;
      illegal_q   <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (kill) begin
        state_q     <= ST_IDLE;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (accept_s) begin
              tag_q <= rd_tag_in;
              if (quick_s) begin
                state_q     <= ST_DONE;
                out_valid_q <= 1'b1;
                result_q    <= quick_res_s;
                illegal_q   <= ~legal_s;
              end else begin
                state_q     <= is_mul_s ? ST_MUL : ST_DIV;
                out_valid_q <= 1'b0;
                illegal_q   <= 1'b0;
              end
            end else if ((state_q == ST_DONE) && out_ready) begin
              state_q     <= ST_IDLE;
              out_valid_q <= 1'b0;
            end
          end
          ST_MUL, ST_DIV: begin
            if (md_last_s) state_q <= ST_FIX;
          end
          ST_FIX: begin
            result_q    <= md_res_s;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
          default: begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign rd_tag_out = tag_q;
  assign illegal    = illegal_q;

endmodule
